// File: rtl/regbank_writeback.sv
// regbank_writeback: sole driver of the register bank write port. ALU results take priority; multi-cycle
// results queue in a small FIFO. A busy scoreboard tracks pending multi-cycle writes. Option: REGBANK_WB_BYPASS_EN.
module regbank_writeback #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_we,
    input  logic [3:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        mu_valid,
    input  logic [3:0]  mu_addr,
    input  logic [31:0] mu_data,
    output logic        mu_ready,
    input  logic        issue_valid,
    input  logic [3:0]  issue_addr,
    output logic [15:0] busy,
    output logic        we,
    output logic [3:0]  addr_d,
    output logic [31:0] data_d
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [3:0]       fifo_addr [FIFO_DEPTH];
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             bypass;
    logic             fifo_wr;
    logic             wr_valid;
    logic [3:0]       wr_addr;
    logic [31:0]      wr_data;
    logic             clr_en;
    logic [15:0]      busy_next;

    // Readiness depends only on the registered count, so a pop never opens a slot in the same cycle.
    assign mu_ready   = (count != FULL_CNT);
    assign fifo_empty = (count == '0);

    always_comb begin
        push   = mu_valid && mu_ready;
        pop    = !alu_we && !fifo_empty;
        bypass = 1'b0;
`ifdef REGBANK_WB_BYPASS_EN
        bypass = !alu_we && fifo_empty && push;
`endif
        fifo_wr = push && !bypass;
        clr_en  = pop || bypass;
    end

    always_comb begin
        wr_valid = 1'b0;
        wr_addr  = addr_d;
        wr_data  = data_d;
        if (alu_we) begin
            wr_valid = 1'b1;
            wr_addr  = alu_addr;
            wr_data  = alu_data;
        end else if (pop) begin
            wr_valid = 1'b1;
            wr_addr  = fifo_addr[rd_ptr];
            wr_data  = fifo_data[rd_ptr];
        end else if (bypass) begin
            wr_valid = 1'b1;
            wr_addr  = mu_addr;
            wr_data  = mu_data;
        end
    end

    // Clear before set so an issue to the same register on the same edge keeps the bit busy.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (issue_valid) begin
            busy_next[issue_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_addr[wr_ptr] <= mu_addr;
            fifo_data[wr_ptr] <= mu_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({fifo_wr, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we     <= 1'b0;
            addr_d <= '0;
            data_d <= '0;
            busy   <= '0;
        end else begin
            we   <= wr_valid && (wr_addr != 4'd0);
            busy <= busy_next;
            if (wr_valid) begin
                addr_d <= wr_addr;
                data_d <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_regbank_writeback.sv
// Scoreboard bench for regbank_writeback: a queue-based model predicts writes, busy and mu_ready.
module tb_regbank_writeback;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_we = 1'b0;
    logic [3:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        mu_valid = 1'b0;
    logic [3:0]  mu_addr = '0;
    logic [31:0] mu_data = '0;
    logic        mu_ready;
    logic        issue_valid = 1'b0;
    logic [3:0]  issue_addr = '0;
    logic [15:0] busy;
    logic        we;
    logic [3:0]  addr_d;
    logic [31:0] data_d;

    regbank_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_we(alu_we), .alu_addr(alu_addr), .alu_data(alu_data),
        .mu_valid(mu_valid), .mu_addr(mu_addr), .mu_data(mu_data), .mu_ready(mu_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .busy(busy), .we(we), .addr_d(addr_d), .data_d(data_d)
    );

    always #5 clk = ~clk;

    logic [35:0] mq[$];
    logic [35:0] exp_q[$];
    logic [15:0] busy_m = '0;
    logic        chk_en = 1'b0;
    logic [35:0] mon_e;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances by the rules for the coming edge.
    task automatic cycle(input logic aw, input logic [3:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [3:0] ma, input logic [31:0] md,
                         input logic iv, input logic [3:0] ia, output logic acc);
        logic [35:0] e;
        logic        bypassed;
        @(negedge clk);
        #1;
        alu_we = aw; alu_addr = aa; alu_data = ad;
        mu_valid = mv; mu_addr = ma; mu_data = md;
        issue_valid = iv; issue_addr = ia;
        acc = mv && (mq.size() < DEPTH);
        bypassed = 1'b0;
        if (aw) begin
            if (aa != 0) exp_q.push_back({aa, ad});
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e[35:32] != 0) exp_q.push_back(e);
            busy_m[e[35:32]] = 1'b0;
        end
`ifdef REGBANK_WB_BYPASS_EN
        else if (acc) begin
            bypassed = 1'b1;
            if (ma != 0) exp_q.push_back({ma, md});
            busy_m[ma] = 1'b0;
        end
`endif
        if (acc && !bypassed) mq.push_back({ma, md});
        if (iv && ia != 0) busy_m[ia] = 1'b1;
        busy_m[0] = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, a);
    endtask

    task automatic do_reset(input logic pre_we);
        @(posedge clk);
        #1;
        chk("pre_reset_we", {31'd0, we}, {31'd0, pre_we});
        reset = 1'b1;
        #1;
        chk("reset_we", {31'd0, we}, 32'd0);
        chk("reset_busy", {16'd0, busy}, 32'd0);
        chk("reset_addr_d", {28'd0, addr_d}, 32'd0);
        chk("reset_data_d", data_d, 32'd0);
        alu_we = 0; mu_valid = 0; issue_valid = 0;
        mq.delete();
        exp_q.delete();
        busy_m = '0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset_ready", {31'd0, mu_ready}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!reset && chk_en) begin
            chk("mu_ready", {31'd0, mu_ready}, {31'd0, (mq.size() < DEPTH)});
            chk("busy", {16'd0, busy}, {16'd0, busy_m});
            if (we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_write: got addr %0d data %h, expected no write at %0t", addr_d, data_d, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", {28'd0, addr_d}, {28'd0, mon_e[35:32]});
                    chk("wr_data", data_d, mon_e[31:0]);
                end
            end else if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missing_write: got we=0, expected addr %0d data %h at %0t", mon_e[35:32], mon_e[31:0], $time);
            end
        end
    end

    initial begin
        logic a;
        int   idx;
        logic [3:0] regs [3];
        regs[0] = 4'd1; regs[1] = 4'd2; regs[2] = 4'd3;

        repeat (2) @(posedge clk);
        do_reset(1'b0);
        chk_en = 1'b1;
        idle(2);

        cycle(1, 4'd5, 32'h1234, 0, 0, 0, 0, 0, a);
        idle(2);
        cycle(1, 4'd0, 32'h1234, 0, 0, 0, 0, 0, a);
        idle(2);

        cycle(0, 0, 0, 0, 0, 0, 1, 4'd7, a);
        idle(2);
        cycle(0, 0, 0, 1, 4'd7, 32'hDEADBEEF, 0, 0, a);
        idle(3);

        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1, regs[i], a);
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(c < 4, 4'd9, 32'hA000_0000 + 32'(c),
                  idx < 3, (idx < 3) ? regs[idx] : 4'd0, 32'hB000_0000 + 32'(idx), 0, 0, a);
            if (a) idx++;
        end
        chk("held_offers_accepted", 32'(idx), 32'd3);
        idle(3);

        cycle(0, 0, 0, 0, 0, 0, 1, 4'd4, a);
        cycle(0, 0, 0, 1, 4'd4, 32'h4444, 1, 4'd4, a);
        cycle(0, 0, 0, 0, 0, 0, 1, 4'd4, a);
        idle(3);

        cycle(0, 0, 0, 1, 4'd0, 32'h0BAD, 0, 0, a);
        idle(3);

        cycle(1, 4'd6, 32'h66, 1, 4'd1, 32'h11, 1, 4'd1, a);
        cycle(1, 4'd6, 32'h67, 1, 4'd2, 32'h22, 1, 4'd2, a);
        cycle(1, 4'd9, 32'h99, 0, 0, 0, 0, 0, a);
        do_reset(1'b1);
        idle(4);

        for (int c = 0; c < 600; c++) begin
            cycle($urandom_range(0, 9) < 4, 4'($urandom), $urandom,
                  $urandom_range(0, 1) == 1, 4'($urandom), $urandom,
                  $urandom_range(0, 2) == 0, 4'($urandom), a);
        end
        idle(6);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regbank_writeback.md
Name: regbank_writeback

Overview:
- Write-side front end for the CPU register bank; the sole driver of its write port (we, addr_d, data_d).
- Merges two result sources onto the single write port:
  - single-cycle ALU writeback, which has absolute priority;
  - multi-cycle unit (memory load / divider) results, buffered in a small FIFO with a valid/ready handshake.
- Keeps a 16-bit busy scoreboard of registers with outstanding multi-cycle results, for hazard/stall logic upstream.

Parameters:
- FIFO_DEPTH, 2, entries in the multi-cycle result FIFO; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_we  in  1  ALU result valid this cycle; always accepted, no back-pressure.
- alu_addr  in  4  ALU destination register.
- alu_data  in  32  ALU result.
- mu_valid  in  1  multi-cycle result offered.
- mu_addr  in  4  multi-cycle destination register.
- mu_data  in  32  multi-cycle result.
- mu_ready  out  1  FIFO can accept; transfer occurs when mu_valid && mu_ready at a rising edge.
- issue_valid  in  1  multi-cycle op issued this cycle; marks its destination busy.
- issue_addr  in  4  destination of the issued op.
- busy  out  16  scoreboard; bit i = reg i has a pending multi-cycle write.
- we  out  1  register bank write enable.
- addr_d  out  4  register bank write address.
- data_d  out  32  register bank write data.

Behaviour:
- Reset (async, immediate):
  - we=0, addr_d=0, data_d=0, busy=0;
  - FIFO read/write pointers and count cleared;
  - mu_ready=1 once reset deasserts.
- we, addr_d and data_d are registered and updated every rising edge. With no write, we=0 and addr_d/data_d hold their previous values.
- Output select at each edge, in priority order:
  1. alu_we=1: output {1, alu_addr, alu_data}; FIFO not popped.
  2. else FIFO non-empty: pop head and output {head_addr!=0, head_addr, head_data}.
  3. else: we=0.
- ALU latency: alu_we in cycle N gives we=1 in cycle N+1.
- Register 0: a write to addr 0 (from either source) drives we=0. The FIFO entry is still popped and the ALU slot is still consumed.
- FIFO:
  - push on mu_valid && mu_ready;
  - mu_ready = (count != FIFO_DEPTH), combinational from count only; a pop in the same cycle does NOT raise mu_ready while full;
  - simultaneous push and pop when neither full nor empty: count unchanged; entry order preserved (FIFO);
  - pointers wrap modulo FIFO_DEPTH.
- Multi-cycle latency (no bypass): handshake at edge N writes the FIFO; the earliest pop is at edge N+1, so we=1 in the cycle after edge N+1. Each cycle with alu_we=1 delays the pop by one cycle (starvation allowed; upstream guarantees gaps).
- Scoreboard:
  - issue_valid with issue_addr!=0 sets busy[issue_addr] at the edge;
  - a pop that writes reg r (r!=0) clears busy[r] at the same edge;
  - set and clear of the same bit in one edge: set wins;
  - ALU writes never touch busy;
  - issue_addr=0 is ignored; busy[0] is always 0.
- Reset mid-operation: FIFO contents discarded, busy cleared, any in-flight write is lost (we=0 immediately).

Optional Feature:
- Macro: REGBANK_WB_BYPASS_EN.
- Defined: if alu_we=0, the FIFO is empty and mu_valid && mu_ready at edge N, the result bypasses the FIFO:
  - output {mu_addr!=0, mu_addr, mu_data} at edge N; we=1 in cycle N+1;
  - FIFO count unchanged;
  - busy[mu_addr] cleared as for a pop.
- Undefined: every multi-cycle result goes through the FIFO (minimum two-edge latency as above). No other difference.

Test Plan:
- Reset then idle: busy=0, we=0, mu_ready=1; assert reset mid-write -> we drops to 0 asynchronously, FIFO empties.
- alu_we=1, alu_addr=5, alu_data=0x1234 in cycle 1 -> cycle 2: we=1, addr_d=5, data_d=0x1234; cycle 3: we=0. Same stimulus with alu_addr=0 -> we stays 0.
- issue_valid, issue_addr=7 -> busy[7]=1; later mu_valid, addr=7, data=0xDEADBEEF with alu_we=0:
  - without bypass: we=1, addr_d=7 two cycles after the handshake edge; busy[7] clears on that edge;
  - with REGBANK_WB_BYPASS_EN: one cycle after the handshake edge.
- Hold alu_we=1 for 4 cycles while offering mu results to regs 1, 2, 3:
  - mu_ready falls after 2 pushes; reg 3 waits;
  - after alu_we drops: regs 1, 2, 3 written in order on consecutive cycles.
- Same-edge issue_valid(addr=4) and pop of a reg-4 result -> busy[4] remains 1.
- FIFO full with simultaneous pop and mu_valid -> no push that cycle (mu_ready=0); push accepted the next cycle; no entry lost or duplicated.
